// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the 2:1 width-converting FIFO.
package fifo_pkg;

  typedef enum logic {
    HALF_UPPER = 1'b0,
    HALF_LOWER = 1'b1
  } half_t;

  localparam int DEFAULT_ADDR_WIDTH = 4;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Pointer, half-select and occupancy controller for the 2:1 register-file FIFO.
// Words are pushed whole and popped as two halves, upper half first.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  same_read,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH+1:0] count
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int WW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [WW-1:0]         words;
  logic [WW-1:0]         words_next;
  half_t                 half;
  half_t                 half_next;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  retire;

  // A half-consumed word still occupies its slot, so flags come from words, not pointers.
  assign full      = (words == WW'(DEPTH));
  assign empty     = (words == '0);
  assign same_read = (half == HALF_LOWER);
  assign count     = {1'b0, words, 1'b0} - (ADDR_WIDTH+2)'(same_read);
  assign w_addr    = wptr;
  assign r_addr    = rptr;
  assign w_en      = wr_ok;

  always_comb begin
    rd_ok      = 1'b0;
    retire     = 1'b0;
    wr_ok      = 1'b0;
    half_next  = half;
    words_next = words;

    rd_ok  = rd & ~empty;
    retire = rd_ok & (half == HALF_LOWER);
    // While full, a write may land only when this cycle frees the oldest slot.
    wr_ok  = reset_n & wr & (~full | retire);

    if (rd_ok) begin
      half_next = (half == HALF_UPPER) ? HALF_LOWER : HALF_UPPER;
    end
    words_next = words + WW'(wr_ok) - WW'(retire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      words <= '0;
      half  <= HALF_UPPER;
    end else begin
      half  <= half_next;
      words <= words_next;
      if (wr_ok) begin
        wptr <= wptr + ADDR_WIDTH'(1);
      end
      if (retire) begin
        rptr <= rptr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl with a behavioural register file and a byte-queue model.
module tb_fifo_rd_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset_n;
  logic          wr;
  logic          rd;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          same_read;
  logic          empty;
  logic          full;
  logic [AW+1:0] count;

  logic [15:0] wdata;
  logic [15:0] mem [DEPTH];
  logic [7:0]  r_data;

  typedef struct {
    logic          w_en;
    logic          full;
    logic          empty;
    logic          same_read;
    logic [AW+1:0] count;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] data_q[$];
  logic [7:0] model_q[$];
  int         wr_total;
  int         ret_total;
  int         checks;
  int         errors;

  fifo_rd_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr       (wr),
    .rd       (rd),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .r_addr   (r_addr),
    .same_read(same_read),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_en) mem[w_addr] <= wdata;
  end
  assign r_data = same_read ? mem[r_addr][7:0] : mem[r_addr][15:8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One cycle: issue the request, predict the response from the byte queue, then retire it.
  task automatic applyStimulus(input logic w, input logic r, input logic [15:0] d);
    exp_t e;
    int   size;
    int   occ;
    logic lower;
    logic rok;
    logic wok;
    wr    = w;
    rd    = r;
    wdata = d;
    size  = model_q.size();
    occ   = (size + 1) / 2;
    lower = (size % 2) == 1;
    rok   = r && size > 0;
    wok   = w && (occ < DEPTH || (rok && lower));
    e.w_en      = wok;
    e.full      = (occ == DEPTH);
    e.empty     = (size == 0);
    e.same_read = lower;
    e.count     = (AW+2)'(size);
    e.w_addr    = AW'(wr_total % DEPTH);
    e.r_addr    = AW'(ret_total % DEPTH);
    exp_q.push_back(e);
    if (rok) data_q.push_back(model_q[0]);
    @(posedge clk);
    #1;
    if (rok) begin
      void'(model_q.pop_front());
      if (lower) ret_total++;
    end
    if (wok) begin
      model_q.push_back(d[15:8]);
      model_q.push_back(d[7:0]);
      wr_total++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_full"}, 32'(full), 32'd0);
    checkOutput({tag, "_count"}, 32'(count), 32'd0);
    checkOutput({tag, "_same_read"}, 32'(same_read), 32'd0);
    checkOutput({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    checkOutput({tag, "_r_addr"}, 32'(r_addr), 32'd0);
    checkOutput({tag, "_w_en"}, 32'(w_en), 32'd0);
  endtask

  task automatic clearModel();
    model_q.delete();
    exp_q.delete();
    data_q.delete();
    wr_total  = 0;
    ret_total = 0;
  endtask

  // Monitor: compares every predicted cycle and every read the DUT actually performs.
  always @(negedge clk) begin
    if (reset_n) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("w_en", 32'(w_en), 32'(e.w_en));
        checkOutput("full", 32'(full), 32'(e.full));
        checkOutput("empty", 32'(empty), 32'(e.empty));
        checkOutput("same_read", 32'(same_read), 32'(e.same_read));
        checkOutput("count", 32'(count), 32'(e.count));
        checkOutput("w_addr", 32'(w_addr), 32'(e.w_addr));
        checkOutput("r_addr", 32'(r_addr), 32'(e.r_addr));
      end
      if (rd && !empty) begin
        if (data_q.size() == 0) checkOutput("unexpected_read", 32'd1, 32'd0);
        else checkOutput("r_data", 32'(r_data), 32'(data_q.pop_front()));
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    wr        = 1'b0;
    rd        = 1'b0;
    wdata     = '0;
    reset_n   = 1'b0;
    wr_total  = 0;
    ret_total = 0;
    #1;
    checkResetValues("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Basic order: one word, two halves.
    applyStimulus(1'b1, 1'b0, 16'hABCD);
    applyStimulus(1'b0, 1'b1, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'h0);

    // Fill plus a rejected fifth write, then drain eight halves.
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 16'(i * 16'h1111));
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'h0);

    // Underflow attempts, then normal use.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'h1234);
    applyStimulus(1'b0, 1'b1, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'h0);

    // Full with a half-consumed word, then write alongside the retiring read.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'($urandom));
    applyStimulus(1'b0, 1'b1, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'h5A5A);
    applyStimulus(1'b1, 1'b0, 16'hDEAD);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'h0);

    // Randomised phases: write-heavy, balanced 1:2, read-heavy.
    for (int i = 0; i < 150; i++)
      applyStimulus($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 50, 16'($urandom));
    for (int i = 0; i < 60; i++)
      applyStimulus((i % 2) == 0, 1'b1, 16'($urandom));
    for (int i = 0; i < 150; i++)
      applyStimulus($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 80, 16'($urandom));

    // Asynchronous reset while the oldest word is half-read.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h7788);
    applyStimulus(1'b0, 1'b1, 16'h0);
    checkOutput("pre_reset_same_read", 32'(same_read), 32'd1);
    wr = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    clearModel();
    @(posedge clk);
    #1;
    wr      = 1'b0;
    reset_n = 1'b1;

    applyStimulus(1'b1, 1'b1, 16'h9911);
    applyStimulus(1'b0, 1'b1, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 100; i++)
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 99) < 60, 16'($urandom));
    applyStimulus(1'b0, 1'b0, 16'h0);

    @(negedge clk);
    #1;
    checkOutput("pending_expectations", 32'(exp_q.size()), 32'd0);
    checkOutput("pending_reads", 32'(data_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
